freq_hop_ram_reader: RTL

- Downstream consumer of the freq_hop_ram_buffer ping-pong RAM.
  - Port A is written as 256 x 32-bit words.
  - Port B is read as 1024 x 8-bit hop codes.
- On each hop-timing strobe, fetches the next 8-bit hop code from the active bank and presents it to the DSP with a valid pulse.
- Alternates banks: bank 0 = bytes 0..511, bank 1 = bytes 512..1023.
- Handshakes bank fill/consume with the upstream writer and flags underrun when a bank is not ready.

---
 rtl/freq_hop_ram_reader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/freq_hop_ram_reader.sv
// freq_hop_ram_reader: strobe-driven hop-code fetch from the two-bank port-B view of the ping-pong RAM.
// Latency: read 1 cycle and valid RD_LAT+2 cycles after hop_strobe_in. Back-to-back strobes give back-to-back valids.
// Backpressure: none toward the DSP. A strobe on an unfilled bank flags underrun. Counter option: FREQ_HOP_UNDERRUN_CNT_EN.
module freq_hop_ram_reader #(
  parameter int HOP_PER_BANK = 512,
  parameter int RD_LAT       = 1
) (
  input  logic        clk_200M_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        stop_in,
  input  logic        bank_ready_in,
  input  logic        bank_ready_sel_in,
  input  logic        hop_strobe_in,
  output logic        ram_rd_en_out,
  output logic [9:0]  ram_addr_rd_out,
  input  logic [7:0]  ram_dout_in,
  output logic [7:0]  dsp_freq_hop_out,
  output logic        dsp_freq_valid_out,
  output logic        bank_done_out,
  output logic        bank_done_sel_out,
  output logic        active_bank_out,
  output logic        underrun_out
`ifdef FREQ_HOP_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt_out
`endif
);

  localparam logic [8:0] LAST_IDX = 9'(HOP_PER_BANK - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BANK,
    ST_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        idx_q, idx_d;
  logic              bank_q, bank_d;
  logic [1:0]        ready_q, ready_d;
  logic [RD_LAT-1:0] rd_vld_sr;

  logic active;
  logic go;
  logic kill;
  logic last_hop;
  logic rd_fire;
  logic underrun_hit;

  assign active   = (state_q != ST_IDLE);
  assign go       = start_in & ~stop_in;
  // A restart from a running state behaves like stop: flush reads and drop ready flags.
  assign kill     = stop_in | (go & active);
  assign last_hop = (idx_q == LAST_IDX);

  // Being in RUN implies ready[bank]; WAIT_BANK serves a strobe in the cycle its flag shows up.
  assign rd_fire      = hop_strobe_in & ~stop_in & ~start_in & active &  ready_q[bank_q];
  assign underrun_hit = hop_strobe_in & ~stop_in & ~start_in & active & ~ready_q[bank_q];

  always_ff @(posedge clk_200M_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bank_d  = bank_q;
    ready_d = ready_q;

    if (kill) begin
      idx_d   = '0;
      bank_d  = 1'b0;
      ready_d = 2'b00;
    end

    if (stop_in) begin
      state_d = ST_IDLE;
    end else if (start_in) begin
      state_d = ST_WAIT_BANK;
      idx_d   = '0;
      bank_d  = 1'b0;
    end else if (active) begin
      if (rd_fire && last_hop) begin
        idx_d            = '0;
        bank_d           = ~bank_q;
        ready_d[bank_q]  = 1'b0;
        state_d          = ready_q[~bank_q] ? ST_RUN : ST_WAIT_BANK;
      end else begin
        if (rd_fire) begin
          idx_d = idx_q + 9'd1;
        end
        state_d = ready_q[bank_q] ? ST_RUN : ST_WAIT_BANK;
      end
    end

    // Writer's set is applied last so it beats a same-cycle consume or stop.
    if (bank_ready_in) begin
      ready_d[bank_ready_sel_in] = 1'b1;
    end
  end

  always_ff @(posedge clk_200M_in) begin
    if (rst_in) begin
      idx_q              <= '0;
      bank_q             <= 1'b0;
      ready_q            <= 2'b00;
      rd_vld_sr          <= '0;
      ram_rd_en_out      <= 1'b0;
      ram_addr_rd_out    <= '0;
      dsp_freq_hop_out   <= '0;
      dsp_freq_valid_out <= 1'b0;
      bank_done_out      <= 1'b0;
      bank_done_sel_out  <= 1'b0;
      underrun_out       <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      bank_q  <= bank_d;
      ready_q <= ready_d;

      ram_rd_en_out <= rd_fire;
      if (rd_fire) begin
        ram_addr_rd_out <= {bank_q, idx_q};
      end

      bank_done_out <= rd_fire & last_hop;
      if (rd_fire && last_hop) begin
        bank_done_sel_out <= bank_q;
      end

      // Stage RD_LAT-1 lines up with the cycle in which doutb carries the issued read.
      rd_vld_sr          <= kill ? '0 : ((rd_vld_sr << 1) | RD_LAT'(ram_rd_en_out));
      dsp_freq_valid_out <= rd_vld_sr[RD_LAT-1] & ~kill;
      if (rd_vld_sr[RD_LAT-1] && !kill) begin
        dsp_freq_hop_out <= ram_dout_in;
      end

      if (go) begin
        underrun_out <= 1'b0;
      end else if (underrun_hit) begin
        underrun_out <= 1'b1;
      end
    end
  end

  assign active_bank_out = bank_q;

`ifdef FREQ_HOP_UNDERRUN_CNT_EN
  always_ff @(posedge clk_200M_in) begin
    if (rst_in || go) begin
      underrun_cnt_out <= '0;
    end else if (underrun_hit && (underrun_cnt_out != 16'hFFFF)) begin
      underrun_cnt_out <= underrun_cnt_out + 16'd1;
    end
  end
`endif

endmodule
